// File: rtl/tnn_eval_sequencer_pkg.sv
// tnn_eval_sequencer_pkg: shared state encodings, default sizes and width helper
package tnn_eval_sequencer_pkg;
    localparam int FEAT_CNT_DEF = 11;
    localparam int FEAT_BITS_DEF = 4;
    localparam int CLASS_CNT_DEF = 7;
    localparam int TEST_CNT_DEF = 1000;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic int width_of(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int AW = width_of(TEST_CNT_DEF);
    localparam int CLS_W = width_of(CLASS_CNT_DEF);
    localparam int CNT_W = $clog2(TEST_CNT_DEF + 1);
endpackage

// File: rtl/tnn_eval_sequencer_if.sv
// tnn_eval_sequencer_if: test/gold memory bus; data is valid one cycle after rd
interface tnn_eval_sequencer_if #(
    parameter int AW = 10,
    parameter int DW = 44,
    parameter int CLS_W = 3
);
    logic [AW-1:0] addr;
    logic rd;
    logic [DW-1:0] test_data;
    logic [CLS_W-1:0] gold_data;

    modport master (output addr, rd, input test_data, gold_data);
    modport slave (input addr, rd, output test_data, gold_data);
endinterface

// File: rtl/tnn_eval_sequencer_settle_timer.sv
// tnn_settle_timer: loadable down-counter that stops at zero
module tnn_settle_timer
    import tnn_eval_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic [TIMER_W-1:0] load_value,
    output logic zero
);
    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_value;
        else if (cnt != '0)
            cnt <= cnt - TIMER_W'(1);
    end

    assign zero = cnt == '0;
endmodule

// File: rtl/tnn_eval_sequencer.sv
// tnn_eval_sequencer: walks the stored test set through the classifier and
// counts how many predictions match the gold labels.
module tnn_eval_sequencer
    import tnn_eval_sequencer_pkg::*;
#(
    parameter int FEAT_CNT = FEAT_CNT_DEF,
    parameter int FEAT_BITS = FEAT_BITS_DEF,
    parameter int CLASS_CNT = CLASS_CNT_DEF,
    parameter int TEST_CNT = TEST_CNT_DEF,
    parameter int SETTLE_CYCLES = 4,
    localparam int FW = FEAT_CNT * FEAT_BITS,
    localparam int CW = width_of(CLASS_CNT),
    localparam int MW = width_of(TEST_CNT),
    localparam int NW = $clog2(TEST_CNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    tnn_eval_sequencer_if.master mem,
    output logic [FW-1:0] features,
    input  logic [CW-1:0] prediction,
    output logic [NW-1:0] correct_cnt,
    output logic [NW-1:0] tests_done
);
    state_t state, state_n;
    logic [CW-1:0] gold_q;
    logic tmr_load, tmr_zero, last;

    assign last = mem.addr == MW'(TEST_CNT - 1);

    tnn_settle_timer u_timer (
        .clk(clk),
        .rst(rst),
        .load(tmr_load),
        .load_value(TIMER_W'(SETTLE_CYCLES - 1)),
        .zero(tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        mem.rd = state == FETCH;
        tmr_load = state == LOAD;
        case (state)
            IDLE, DONE: state_n = start ? FETCH : state;
            FETCH:      state_n = LOAD;
            LOAD:       state_n = SETTLE;
            SETTLE:     state_n = tmr_zero ? CHECK : SETTLE;
            CHECK:      state_n = last ? DONE : FETCH;
            default:    state_n = IDLE;
        endcase
    end

    // prediction is only trusted in CHECK, after the settle window has elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            mem.addr <= '0;
            features <= '0;
            gold_q <= '0;
            correct_cnt <= '0;
            tests_done <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    correct_cnt <= '0;
                    tests_done <= '0;
                    mem.addr <= '0;
                    done <= 1'b0;
                    busy <= 1'b1;
                end
                LOAD: begin
                    features <= mem.test_data;
                    gold_q <= mem.gold_data;
                end
                CHECK: begin
                    correct_cnt <= correct_cnt + NW'(prediction == gold_q);
                    tests_done <= tests_done + NW'(1);
                    if (last) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else
                        mem.addr <= mem.addr + MW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/tnn_eval_sequencer.md
Name: tnn_eval_sequencer

Overview:
- Clocked controller that drives the combinational TNN classifier `top` through a stored test set.
- Fetches one feature vector per test from a synchronous-read test memory and applies it to the classifier.
- Waits a programmable settle time, compares `prediction` against the gold label and counts correct classifications.
- Sits between the test/gold memories and `top`; it is the on-chip counterpart of the accuracy measurement run in simulation.

Parameters:
- FEAT_CNT, 11, number of input features (shared parameters.vh value).
- FEAT_BITS, 4, bits per feature (shared parameters.vh value).
- CLASS_CNT, 7, number of classes; label width CLS_W = max(1, $clog2(CLASS_CNT)).
- TEST_CNT, 1000, number of test vectors; address width AW = max(1, $clog2(TEST_CNT)).
- SETTLE_CYCLES, 4, cycles the features are held before sampling prediction; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to run the full test set; sampled in IDLE or DONE only.
- busy  out  1  high while a run is in progress.
- done  out  1  high from end of run until next accepted start or reset.
- mem_addr  out  AW  test index presented to the test and gold memories.
- mem_rd  out  1  read strobe; memory data is valid exactly 1 cycle after mem_rd=1.
- test_data  in  FEAT_CNT*FEAT_BITS  feature vector from test memory.
- gold_data  in  CLS_W  gold label from gold memory, same timing as test_data.
- features  out  FEAT_CNT*FEAT_BITS  registered vector driven into `top`.
- prediction  in  CLS_W  classifier output.
- correct_cnt  out  $clog2(TEST_CNT+1)  number of matches in the current/last run.
- tests_done  out  $clog2(TEST_CNT+1)  number of vectors checked so far.

Behaviour:
- Reset values (asynchronous):
  - Outputs: busy=0, done=0, mem_rd=0, mem_addr=0, features=0, correct_cnt=0, tests_done=0.
  - Internal: state=IDLE, settle counter=0, gold register=0.
- States: IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1:
  - clear correct_cnt, tests_done and mem_addr to 0; done<=0; busy<=1; go to FETCH.
  - In DONE, start=0 holds DONE and keeps done=1.
- FETCH (1 cycle): mem_rd=1 combinationally for this cycle with mem_addr current; go to LOAD.
- LOAD (1 cycle): features<=test_data, gold register<=gold_data, settle counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: features held constant; counter decrements each cycle. When the counter equals 0 in a cycle, go to CHECK next; SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - if prediction==gold register, correct_cnt+1; tests_done+1.
  - if mem_addr==TEST_CNT-1, go to DONE: busy<=0, done<=1.
  - else mem_addr+1 and go to FETCH.
- Per-vector latency is SETTLE_CYCLES+3 cycles. A full run is TEST_CNT*(SETTLE_CYCLES+3) cycles from start accept to done rising.
- start while busy is ignored; there is no restart mid-run.
- features keeps the last applied vector after DONE; it is not cleared.
- mem_addr never exceeds TEST_CNT-1, so there is no wrap-around.
- correct_cnt ≤ tests_done ≤ TEST_CNT always; no overflow is possible by width choice.
- Reset asserted mid-run aborts immediately to reset values. The partial counts are discarded.
- prediction is sampled only in CHECK; glitches during SETTLE are ignored.
- TEST_CNT=1: single pass, done after SETTLE_CYCLES+3 cycles.

Decomposition:
- Shared header, alongside parameters.vh, holds:
  - state encodings: 3-bit localparams IDLE=0, FETCH=1, LOAD=2, SETTLE=3, CHECK=4, DONE=5;
  - width localparams AW, CLS_W, CNT_W.
- One sub-module is natural: tnn_settle_timer.
  - Loadable down-counter with load, load_value and zero outputs; 8 bits wide.
  - Reused later for multi-cycle classifier variants.
- `top` is instantiated outside this block, not inside it.

Test Plan:
- TEST_CNT=4, SETTLE_CYCLES=2, all 4 golds matching a behavioural model of `top`, start pulse → done rises 20 cycles after start accept; correct_cnt=4, tests_done=4, busy=0.
- Same setup with gold[1] and gold[3] corrupted → correct_cnt=2, tests_done=4; features at done equals test[3].
- start pulsed again at cycles 3 and 10 of a run → ignored; run finishes at cycle 20 with unchanged counts. A later start from DONE clears counts and repeats the run with an identical result.
- rst asserted during SETTLE of vector 2 → busy, done, mem_addr, correct_cnt and tests_done are all 0 asynchronously. The next start runs a full 4-vector pass correctly.
- SETTLE_CYCLES=1, TEST_CNT=1 → mem_rd pulses once at addr 0; done after 4 cycles; correct_cnt=1 when matching.
- `prediction` forced to toggle during SETTLE and stable only in CHECK → the count reflects only the CHECK-cycle value.
